// File: rtl/dcr_pkg.sv
// dcr_pkg: shared state, slot types and source-match helper for the stall controller
package dcr_pkg;
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, ERR} stl_state_t;
  typedef struct packed {
    logic       valid;
    logic       is_ld;
    logic       is_st;
    logic [4:0] dst;
  } slot_t;
  function automatic logic src_match(input logic [4:0] src, input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
    return (src != 5'd0) && ((src == rs) || (uses_rt && (src == rt)));
  endfunction
endpackage

// File: rtl/dcr_sat_cnt.sv
// dcr_sat_cnt: up-counter that sticks at all-ones instead of wrapping
module dcr_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  assign count = count_q;
  always_comb count_d = (inc && !(&count_q)) ? count_q + {{(W-1){1'b0}}, 1'b1} : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
endmodule

// File: rtl/dcr_stall_ctl.sv
// dcr_stall_ctl: load-use/branch-on-load interlock and data-memory freeze controller
module dcr_stall_ctl
  import dcr_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsInSTL,
  input  logic [4:0]       RtInSTL,
  input  logic             UsesRtInSTL,
  input  logic             BranchInSTL,
  input  logic             MemReadInSTL,
  input  logic             MemWriteInSTL,
  input  logic [4:0]       WriteAddrInSTL,
  input  logic             MemAckInMEM,
  output logic             ClkEnOut,
  output logic             StallOutIF,
  output logic             BubbleOutEXE,
  output logic             MemReqOutMEM,
  output logic             MemErrOut,
  output logic [CNT_W-1:0] StallCyclesOut
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  stl_state_t    state_q, state_d, saved_q, saved_d, eff;
  slot_t         exe_q, exe_d, mem_q, mem_d;
  logic [1:0]    lu_cnt_q, lu_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          freeze, ld_use, mem_br, hazard;
  assign MemReqOutMEM = ~rst & mem_q.valid & (mem_q.is_ld | mem_q.is_st);
  assign MemErrOut    = state_q == ERR;
  always_comb begin
    freeze       = mem_q.valid & (mem_q.is_ld | mem_q.is_st) & ~MemAckInMEM;
    eff          = (state_q == MEM_WAIT && MemAckInMEM) ? saved_q : state_q;
    ld_use       = exe_q.valid & exe_q.is_ld & src_match(exe_q.dst, RsInSTL, RtInSTL, UsesRtInSTL);
    mem_br       = BranchInSTL & mem_q.valid & mem_q.is_ld & src_match(mem_q.dst, RsInSTL, RtInSTL, UsesRtInSTL);
    hazard       = ld_use | mem_br;
    ClkEnOut     = ~rst & (eff == RUN || eff == LU_STALL) & ~freeze;
    StallOutIF   = ~rst & ((eff == RUN) ? hazard & ~freeze : 1'b1);
    BubbleOutEXE = ~rst & ~freeze & ((eff == RUN) ? hazard : eff == LU_STALL);
  end
  always_comb begin
    state_d    = eff;
    saved_d    = saved_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_d      = ClkEnOut ? exe_q : mem_q;
    exe_d      = ClkEnOut ? (BubbleOutEXE ? '0 : slot_t'({1'b1, MemReadInSTL, MemWriteInSTL, WriteAddrInSTL})) : exe_q;
    if ((eff == RUN || eff == LU_STALL) && freeze) begin
      state_d    = MEM_WAIT;
      saved_d    = eff;
      wait_cnt_d = WW'(1);
    end else if (eff == RUN && ld_use && BranchInSTL) begin
      state_d  = LU_STALL;
      lu_cnt_d = 2'd1;
    end else if (eff == LU_STALL) begin
      lu_cnt_d = (lu_cnt_q == 2'd0) ? 2'd0 : lu_cnt_q - 2'd1;
      state_d  = (lu_cnt_q <= 2'd1) ? RUN : LU_STALL;
    end else if (eff == MEM_WAIT) begin
      state_d    = (wait_cnt_q == WW'(MEM_TIMEOUT)) ? ERR : MEM_WAIT;
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      saved_q    <= RUN;
      exe_q      <= '0;
      mem_q      <= '0;
      lu_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      exe_q      <= exe_d;
      mem_q      <= mem_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
  dcr_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~ClkEnOut | StallOutIF),
    .count(StallCyclesOut)
  );
endmodule

// File: tb/tb_dcr_stall_ctl.sv
// tb_dcr_stall_ctl: scoreboard bench checking the stall controller against an instruction-level model
module tb_dcr_stall_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs = '0, rt = '0, wa = '0;
  logic        uses_rt = 1'b0, br = 1'b0, ld = 1'b0, st = 1'b0, ack = 1'b1;
  logic        clk_en, stall, bubble, req, err;
  logic [31:0] cyc;
  logic        sat_rst = 1'b1, sat_inc = 1'b0;
  logic [2:0]  sat_count;
  always #5 clk = ~clk;
  dcr_stall_ctl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .RsInSTL(rs), .RtInSTL(rt), .UsesRtInSTL(uses_rt),
    .BranchInSTL(br), .MemReadInSTL(ld), .MemWriteInSTL(st), .WriteAddrInSTL(wa),
    .MemAckInMEM(ack), .ClkEnOut(clk_en), .StallOutIF(stall), .BubbleOutEXE(bubble),
    .MemReqOutMEM(req), .MemErrOut(err), .StallCyclesOut(cyc)
  );
  dcr_sat_cnt #(.W(3)) u_sat (.clk(clk), .rst(sat_rst), .inc(sat_inc), .count(sat_count));
  typedef struct {bit [4:0] rs, rt, wa; bit uses_rt, br, ld, st;} instr_t;
  typedef struct {bit v, ld, st; bit [4:0] dst;} mslot_t;
  typedef struct packed {logic ce, stall, bub, req, err; logic [31:0] cnt;} exp_t;
  exp_t   sb[$];
  instr_t prog[$];
  instr_t cur;
  mslot_t m_ex, m_mem;
  int     pend, waited;
  bit     m_err;
  longint m_cnt;
  int     checks = 0, failures = 0;
  exp_t   mon_e, mon_g;
  function automatic instr_t i_nop();
    instr_t i = '{default: 0};
    return i;
  endfunction
  function automatic instr_t i_lw(input bit [4:0] d, input bit [4:0] b);
    instr_t i = i_nop();
    i.rs = b; i.wa = d; i.ld = 1;
    return i;
  endfunction
  function automatic instr_t i_sw(input bit [4:0] b, input bit [4:0] s);
    instr_t i = i_nop();
    i.rs = b; i.rt = s; i.uses_rt = 1; i.st = 1;
    return i;
  endfunction
  function automatic instr_t i_add(input bit [4:0] d, input bit [4:0] s, input bit [4:0] t);
    instr_t i = i_nop();
    i.rs = s; i.rt = t; i.uses_rt = 1; i.wa = d;
    return i;
  endfunction
  function automatic instr_t i_beq(input bit [4:0] s, input bit [4:0] t);
    instr_t i = i_nop();
    i.rs = s; i.rt = t; i.uses_rt = 1; i.br = 1;
    return i;
  endfunction
  function automatic bit reads(input instr_t i, input bit [4:0] r);
    return r != 0 && (i.rs == r || (i.uses_rt && i.rt == r));
  endfunction
  function automatic instr_t i_rand();
    bit [4:0] a = 5'($urandom_range(0, 3));
    bit [4:0] b = 5'($urandom_range(0, 3));
    bit [4:0] c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0, 5: return i_lw(a, b);
      1: return i_sw(a, b);
      2: return i_add(a, b, c);
      3: return i_beq(a, b);
      default: return i_nop();
    endcase
  endfunction
  task automatic step(input bit r, input bit a);
    exp_t e;
    bit ce, s, b, q;
    @(posedge clk);
    #1;
    rst = r; ack = a;
    rs = cur.rs; rt = cur.rt; wa = cur.wa; uses_rt = cur.uses_rt; br = cur.br; ld = cur.ld; st = cur.st;
    e.err = m_err;
    e.cnt = m_cnt[31:0];
    q = m_mem.v && (m_mem.ld || m_mem.st);
    ce = 0; s = 0; b = 0;
    if (r) begin
      m_ex = '{default: 0}; m_mem = '{default: 0};
      pend = 0; waited = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (m_err) s = 1;
      else if (q && !a) begin
        s = waited > 0 || pend > 0;
        if (waited == 16) m_err = 1;
        else waited++;
      end else begin
        ce = 1;
        waited = 0;
        if (pend > 0) begin
          s = 1; b = 1; pend--;
        end else if (m_ex.v && m_ex.ld && reads(cur, m_ex.dst)) begin
          s = 1; b = 1;
          if (cur.br) pend = 1;
        end else if (cur.br && m_mem.v && m_mem.ld && reads(cur, m_mem.dst)) begin
          s = 1; b = 1;
        end
        m_mem = m_ex;
        if (b) m_ex = '{default: 0};
        else m_ex = '{v: 1, ld: cur.ld, st: cur.st, dst: cur.wa};
      end
      if ((!ce || s) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
    e.ce = ce; e.stall = s; e.bub = b; e.req = r ? 1'b0 : q;
    sb.push_back(e);
    if (!r && ce && !s) cur = (prog.size() > 0) ? prog.pop_front() : i_nop();
  endtask
  task automatic run(input int n, input bit a);
    for (int i = 0; i < n; i++) step(0, a);
  endtask
  task automatic chk_sat(input logic [2:0] exp, input string nm);
    checks++;
    if (sat_count !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, sat_count, exp);
    end
  endtask
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        mon_g = {clk_en, stall, bubble, req, err, cyc};
        checks++;
        if (mon_g !== mon_e) begin
          failures++;
          $display("FAIL outputs t=%0t got ce=%b stall=%b bub=%b req=%b err=%b cnt=%0d exp ce=%b stall=%b bub=%b req=%b err=%b cnt=%0d",
                   $time, mon_g.ce, mon_g.stall, mon_g.bub, mon_g.req, mon_g.err, mon_g.cnt,
                   mon_e.ce, mon_e.stall, mon_e.bub, mon_e.req, mon_e.err, mon_e.cnt);
        end
      end
    end
  end
  initial begin : stim
    cur = i_nop();
    m_ex = '{default: 0}; m_mem = '{default: 0};
    pend = 0; waited = 0; m_err = 0; m_cnt = 0;
    repeat (2) step(1, 1);
    run(2, 1);
    prog.push_back(i_lw(2, 1)); prog.push_back(i_add(3, 2, 4));
    run(7, 1);
    prog.push_back(i_lw(2, 1)); prog.push_back(i_beq(2, 5));
    run(8, 1);
    prog.push_back(i_lw(0, 1)); prog.push_back(i_add(3, 0, 0));
    run(6, 1);
    prog.push_back(i_lw(1, 2));
    run(3, 1); run(3, 0); run(4, 1);
    prog.push_back(i_lw(1, 2)); prog.push_back(i_lw(2, 3)); prog.push_back(i_add(3, 2, 0));
    run(3, 1); run(3, 0); run(5, 1);
    prog.push_back(i_lw(2, 1)); prog.push_back(i_beq(2, 5));
    run(3, 1); run(2, 0); run(5, 1);
    prog.push_back(i_lw(1, 2));
    run(3, 1); run(16, 0); run(3, 1);
    prog.push_back(i_lw(1, 2));
    run(3, 1); run(20, 0); run(2, 1);
    step(1, 0);
    run(4, 1);
    prog.push_back(i_lw(2, 1)); prog.push_back(i_beq(2, 5));
    run(3, 1);
    step(1, 1);
    run(4, 1);
    for (int k = 0; k < 4000; k++) begin
      if (prog.size() == 0) prog.push_back(i_rand());
      if ($urandom_range(0, 799) == 0) run(18, 0);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    @(posedge clk); #1 sat_rst = 0; sat_inc = 1;
    repeat (6) @(posedge clk);
    #1 chk_sat(3'd6, "sat_count_6");
    repeat (3) @(posedge clk);
    #1 chk_sat(3'd7, "sat_hold_max");
    sat_inc = 0; sat_rst = 1;
    @(posedge clk);
    #1 chk_sat(3'd0, "sat_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
